// File: rtl/ibex_ex_seq_ctrl.sv
// EX sequencing controller: issues one instruction at a time into ALU/MUL/DIV,
// holds results for writeback, handles kill/timeout and counts EX stall cycles.
module ibex_ex_seq_ctrl #(
    parameter int unsigned MaxCycles = 40,
    parameter int unsigned StallCntW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_valid_i,
    input  logic [1:0]           instr_class_i,
    input  logic                 kill_i,
    input  logic                 ex_valid_i,
    input  logic [1:0]           imd_val_we_i,
    input  logic [33:0]          imd_val_d0_i,
    input  logic [33:0]          imd_val_d1_i,
    input  logic                 wb_ready_i,
    output logic                 alu_instr_first_cycle_o,
    output logic                 mult_en_o,
    output logic                 div_en_o,
    output logic                 multdiv_ready_id_o,
    output logic [33:0]          imd_val_q0_o,
    output logic [33:0]          imd_val_q1_o,
    output logic                 instr_done_o,
    output logic                 ex_busy_o,
    output logic                 timeout_o,
    output logic [StallCntW-1:0] stall_cnt_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // The counter never passes MaxCycles-1: the watchdog returns to IDLE there.
    localparam int unsigned   CntW    = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MaxCycles - 1);

    logic [1:0]           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [33:0]          imd0_q, imd0_d;
    logic [33:0]          imd1_q, imd1_d;
    logic [StallCntW-1:0] stall_q, stall_d;

    logic active;
    logic res_ok;
    logic done;
    logic timeout;

    assign active = instr_valid_i & ~kill_i;

    // In HOLD the result was already produced; only writeback is awaited.
    assign res_ok = (state_q == HOLD) | ex_valid_i;
    assign done   = active & wb_ready_i & res_ok;

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        if (!active) begin
            state_d = IDLE;
        end else if (done) begin
            state_d = IDLE;
        end else if (cnt_q == CntLast) begin
            timeout = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ex_valid_i ? HOLD : BUSY;
                BUSY:    state_d = ex_valid_i ? HOLD : BUSY;
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = (state_d == IDLE) ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        imd0_d = imd0_q;
        imd1_d = imd1_q;
        if (active && imd_val_we_i[0]) imd0_d = imd_val_d0_i;
        if (active && imd_val_we_i[1]) imd1_d = imd_val_d1_i;
    end

    always_comb begin
        stall_d = stall_q;
        if (instr_valid_i && !done && !kill_i && !(&stall_q)) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            imd0_q  <= '0;
            imd1_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            imd0_q  <= imd0_d;
            imd1_q  <= imd1_d;
            stall_q <= stall_d;
        end
    end

    assign alu_instr_first_cycle_o = active & (state_q == IDLE);
    assign mult_en_o               = active & (instr_class_i == 2'd1);
    assign div_en_o                = active & (instr_class_i == 2'd2);
    assign multdiv_ready_id_o      = wb_ready_i;
    assign ex_busy_o               = (state_q != IDLE);
    // A reset cycle must not leak a retire or watchdog pulse.
    assign instr_done_o            = done & ~rst_i;
    assign timeout_o               = timeout & ~rst_i;
    assign imd_val_q0_o            = imd0_q;
    assign imd_val_q1_o            = imd1_q;
    assign stall_cnt_o             = stall_q;

    property p_valid_held;
        @(posedge clk_i) disable iff (rst_i)
            ((state_q != IDLE) && !kill_i) |-> instr_valid_i;
    endproperty
    a_valid_held: assert property (p_valid_held);

    property p_done_xor_timeout;
        @(posedge clk_i) disable iff (rst_i) !(instr_done_o && timeout_o);
    endproperty
    a_done_xor_timeout: assert property (p_done_xor_timeout);

endmodule

// File: tb/tb_ibex_ex_seq_ctrl.sv
// Scoreboard bench for ibex_ex_seq_ctrl: retire/timeout events are queued by
// the stimulus and checked by an independent monitor; enables checked inline.
module tb_ibex_ex_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  cls;
    logic        kill;
    logic        exv;
    logic [1:0]  we;
    logic [33:0] d0, d1;
    logic        wbr;

    logic        first_o, mult_o, div_o, mdr_o, done_o, busy_o, to_o;
    logic [33:0] q0_o, q1_o;
    logic [15:0] stall_o;
    logic        first_4, mult_4, div_4, mdr_4, done_4, busy_4, to_4;
    logic [33:0] q0_4, q1_4;
    logic [3:0]  stall_4;

    always #5 clk = ~clk;

    ibex_ex_seq_ctrl #(.MaxCycles(40), .StallCntW(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(valid), .instr_class_i(cls),
        .kill_i(kill), .ex_valid_i(exv), .imd_val_we_i(we), .imd_val_d0_i(d0),
        .imd_val_d1_i(d1), .wb_ready_i(wbr), .alu_instr_first_cycle_o(first_o),
        .mult_en_o(mult_o), .div_en_o(div_o), .multdiv_ready_id_o(mdr_o),
        .imd_val_q0_o(q0_o), .imd_val_q1_o(q1_o), .instr_done_o(done_o),
        .ex_busy_o(busy_o), .timeout_o(to_o), .stall_cnt_o(stall_o)
    );

    ibex_ex_seq_ctrl #(.MaxCycles(40), .StallCntW(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(valid), .instr_class_i(cls),
        .kill_i(kill), .ex_valid_i(exv), .imd_val_we_i(we), .imd_val_d0_i(d0),
        .imd_val_d1_i(d1), .wb_ready_i(wbr), .alu_instr_first_cycle_o(first_4),
        .mult_en_o(mult_4), .div_en_o(div_4), .multdiv_ready_id_o(mdr_4),
        .imd_val_q0_o(q0_4), .imd_val_q1_o(q1_4), .instr_done_o(done_4),
        .ex_busy_o(busy_4), .timeout_o(to_4), .stall_cnt_o(stall_4)
    );

    typedef struct {
        bit is_to;
        int cyc;
        int stall;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every retire/timeout pulse must match the oldest queued event.
    always @(negedge clk) begin
        if (!rst && (done_o || to_o)) begin
            if (expq.size() == 0) begin
                chk("unexpected_event", {62'd0, done_o, to_o}, 64'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("evt_timeout", to_o, e.is_to);
                chk("evt_done", done_o, !e.is_to);
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_stall", stall_o, e.stall);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid = 0; cls = 0; kill = 0; exv = 0; we = 0; d0 = 0; d1 = 0; wbr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_in();
        tick();
        rst = 0;
    endtask

    task automatic push(input bit is_to, input int c, input int s);
        exp_t e;
        e.is_to = is_to; e.cyc = c; e.stall = s;
        expq.push_back(e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        rst = 1;
        idle_in();
        tick();
        tick();
        rst = 0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_q0", q0_o, 0);
        chk("rst_q1", q1_o, 0);
        chk("rst_first", first_o, 0);
        tick();

        // Single-cycle ALU
        valid = 1; cls = 0; exv = 1; wbr = 1;
        push(0, cyc, 0);
        @(negedge clk);
        chk("alu_first", first_o, 1);
        chk("alu_busy", busy_o, 0);
        chk("alu_mult", mult_o, 0);
        chk("alu_div", div_o, 0);
        chk("alu_mdr", mdr_o, 1);
        tick();
        idle_in();
        @(negedge clk);
        chk("alu_busy_after", busy_o, 0);
        chk("alu_stall", stall_o, 0);
        tick();

        // DIV, result in cycle 36
        do_reset();
        base = cyc;
        push(0, base + 36, 36);
        for (int k = 0; k <= 36; k++) begin
            valid = 1; cls = 2; exv = (k == 36); wbr = 1;
            @(negedge clk);
            chk("div_en", div_o, 1);
            chk("div_mult", mult_o, 0);
            chk("div_busy", busy_o, (k >= 1));
            chk("div_first", first_o, (k == 0));
            tick();
        end
        idle_in();
        @(negedge clk);
        chk("div_idle", busy_o, 0);
        chk("div_en_off", div_o, 0);
        chk("div_stall", stall_o, 36);
        chk("div_stall4_sat", stall_4, 15);
        tick();

        // MULT with writeback back-pressure -> HOLD
        do_reset();
        base = cyc;
        push(0, base + 6, 6);
        for (int k = 0; k <= 6; k++) begin
            valid = 1; cls = 1; exv = (k == 3); wbr = (k == 6);
            we = (k == 1) ? 2'b01 : (k == 2) ? 2'b10 : 2'b00;
            d0 = 34'h1_2345_6789; d1 = 34'h2_AAAA_5555;
            @(negedge clk);
            chk("mul_en", mult_o, 1);
            chk("mul_busy", busy_o, (k >= 1));
            chk("mul_mdr", mdr_o, (k == 6));
            tick();
        end
        idle_in();
        @(negedge clk);
        chk("mul_idle", busy_o, 0);
        chk("mul_q0", q0_o, 34'h1_2345_6789);
        chk("mul_q1", q1_o, 34'h2_AAAA_5555);
        tick();

        // Kill in cycle 5 of a DIV
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            valid = 1; cls = 2; exv = 0; wbr = 1; kill = (k == 5);
            we = (k >= 4) ? 2'b11 : 2'b00;
            d0 = (k == 4) ? 34'h0_0000_AAAA : 34'h3_FFFF_0001;
            d1 = (k == 4) ? 34'h1_0000_BBBB : 34'h2_EEEE_0002;
            @(negedge clk);
            chk("kill_div_en", div_o, (k != 5));
            chk("kill_done", done_o, 0);
            tick();
        end
        idle_in();
        @(negedge clk);
        chk("kill_idle", busy_o, 0);
        chk("kill_q0", q0_o, 34'h0_0000_AAAA);
        chk("kill_q1", q1_o, 34'h1_0000_BBBB);
        chk("kill_stall", stall_o, 5);
        tick();

        // Watchdog: ex_valid never comes
        do_reset();
        base = cyc;
        push(1, base + 39, 39);
        for (int k = 0; k <= 39; k++) begin
            valid = 1; cls = 1; exv = 0; wbr = 1;
            @(negedge clk);
            chk("to_busy", busy_o, (k >= 1));
            tick();
        end
        valid = 1; cls = 0; exv = 1; wbr = 1;
        push(0, base + 40, 40);
        @(negedge clk);
        chk("to_next_first", first_o, 1);
        chk("to_next_busy", busy_o, 0);
        tick();
        idle_in();

        // Stall saturation on the narrow counter, then reset mid-BUSY
        do_reset();
        for (int k = 0; k < 20; k++) begin
            valid = 1; cls = 0; exv = 0; wbr = 0;
            we = (k == 2) ? 2'b11 : 2'b00;
            d0 = 34'h0_1111_2222; d1 = 34'h0_3333_4444;
            @(negedge clk);
            chk("sat_stall4", stall_4, (k > 15) ? 15 : k);
            tick();
        end
        @(negedge clk);
        chk("sat_stall16", stall_o, 20);
        chk("sat_stall4_end", stall_4, 15);
        chk("sat_q0", q0_o, 34'h0_1111_2222);
        chk("sat_busy", busy_o, 1);
        rst = 1;
        tick();
        rst = 0;
        idle_in();
        @(negedge clk);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_stall", stall_o, 0);
        chk("mrst_stall4", stall_4, 0);
        chk("mrst_q0", q0_o, 0);
        chk("mrst_q1", q1_o, 0);
        tick();

        chk("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
